// File: rtl/inst_issue_queue_if.sv
// Handshake bundle between the host, the instruction issue queue and the
// NPU control unit.
//   host side   : h2f_io, h2f_write, h2f_flush -> queue; f2h_status <- queue
//   control side: inst, inst_valid -> control unit; inst_ready, inst_done <- control unit
//   observation : queue_empty, queue_full
// master = environment (host + control unit), slave = issue queue.
interface inst_issue_queue_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] h2f_io;
  logic             h2f_write;
  logic             h2f_flush;
  logic [31:0]      f2h_status;
  logic [WIDTH-1:0] inst;
  logic             inst_valid;
  logic             inst_ready;
  logic             inst_done;
  logic             queue_empty;
  logic             queue_full;

  modport master (
    output h2f_io, h2f_write, h2f_flush, inst_ready, inst_done,
    input  f2h_status, inst, inst_valid, queue_empty, queue_full
  );

  modport slave (
    input  h2f_io, h2f_write, h2f_flush, inst_ready, inst_done,
    output f2h_status, inst, inst_valid, queue_empty, queue_full
  );
endinterface

// File: rtl/inst_issue_queue.sv
// Host-to-NPU instruction buffer: host words are queued in a FIFO and issued
// one at a time to the control unit, waiting for inst_done between issues.
//   clk, rst : clock, synchronous active-high reset
//   bus      : inst_issue_queue_if.slave (host write/flush/status, issue handshake,
//              empty/full flags)
module inst_issue_queue #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  inst_issue_queue_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic [15:0]      issue_cnt_q;
  logic [WIDTH-1:0] inst_q, inst_d;
  logic             inst_valid_q, inst_valid_d;
  logic [31:0]      status_q;
  logic             push_c, pop_c, issue_c, empty_c, full_c;

  assign empty_c = (count_q == CNT_W'(0));
  assign full_c  = (count_q == CNT_W'(DEPTH));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state, issue outputs and FIFO push/pop decisions; flush overrides all
  always_comb begin
    state_d      = state_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    pop_c        = 1'b0;
    issue_c      = 1'b0;
    if (bus.h2f_flush) begin
      if (state_q == S_ISSUE) begin
        state_d      = S_IDLE;
        inst_valid_d = 1'b0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!empty_c) begin
            state_d      = S_ISSUE;
            inst_d       = mem[rd_ptr_q];
            inst_valid_d = 1'b1;
          end
        end
        S_ISSUE: begin
          if (bus.inst_ready) begin
            state_d      = S_WAIT;
            inst_valid_d = 1'b0;
            pop_c        = 1'b1;
            issue_c      = 1'b1;
          end
        end
        S_WAIT: begin
          if (bus.inst_done) state_d = S_IDLE;
        end
        default: begin
          state_d      = S_IDLE;
          inst_valid_d = 1'b0;
        end
      endcase
    end
    // A pop frees the slot this cycle, so a full queue can still accept
    push_c = bus.h2f_write && !bus.h2f_flush && (!full_c || pop_c);
  end

  // Pointers, occupancy, sticky overflow, issue counter and status snapshot
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      issue_cnt_q  <= '0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      status_q     <= 32'h0000_0100;
    end else begin
      status_q     <= {issue_cnt_q, 3'b000, state_q, overflow_q, full_c, empty_c,
                       8'(count_q)};
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      if (issue_c) issue_cnt_q <= issue_cnt_q + 16'd1;
      if (bus.h2f_flush) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        count_q    <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        if (push_c && !pop_c)      count_q <= count_q + CNT_W'(1);
        else if (pop_c && !push_c) count_q <= count_q - CNT_W'(1);
        if (bus.h2f_write && !push_c) overflow_q <= 1'b1;
      end
    end
  end

  // FIFO storage, not reset
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr_q] <= bus.h2f_io;
  end

  assign bus.inst        = inst_q;
  assign bus.inst_valid  = inst_valid_q;
  assign bus.f2h_status  = status_q;
  assign bus.queue_empty = empty_c;
  assign bus.queue_full  = full_c;

endmodule

// File: tb/tb_inst_issue_queue.sv
// Bench for inst_issue_queue: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_inst_issue_queue;

  localparam int unsigned DEPTH = 16;
  localparam int          PH_IDLE  = 0;
  localparam int          PH_ISSUE = 1;
  localparam int          PH_WAIT  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  inst_issue_queue_if #(.WIDTH(32)) bus ();

  inst_issue_queue #(.DEPTH(DEPTH), .WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] mq[$];
  int          m_phase;
  logic        m_valid;
  logic [31:0] m_inst;
  logic        m_ovf;
  logic [15:0] m_icnt;
  logic [31:0] m_status;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model across one clock edge using the currently driven inputs
  task automatic model_edge();
    logic [31:0] snap;
    logic        pop;
    int          occ;
    if (rst) begin
      mq.delete();
      m_phase  = PH_IDLE;
      m_valid  = 1'b0;
      m_inst   = '0;
      m_ovf    = 1'b0;
      m_icnt   = '0;
      m_status = 32'h0000_0100;
      return;
    end
    occ  = mq.size();
    snap = {m_icnt, 3'b000, 2'(m_phase), m_ovf, logic'(occ == DEPTH), logic'(occ == 0), 8'(occ)};
    pop  = 1'b0;
    if (bus.h2f_flush) begin
      mq.delete();
      m_ovf = 1'b0;
      if (m_phase == PH_ISSUE) begin
        m_phase = PH_IDLE;
        m_valid = 1'b0;
      end
    end else begin
      if (m_phase == PH_IDLE && occ != 0) begin
        m_phase = PH_ISSUE;
        m_valid = 1'b1;
        m_inst  = mq[0];
      end else if (m_phase == PH_ISSUE && bus.inst_ready) begin
        m_phase = PH_WAIT;
        m_valid = 1'b0;
        m_icnt  = m_icnt + 16'd1;
        pop     = 1'b1;
      end else if (m_phase == PH_WAIT && bus.inst_done) begin
        m_phase = PH_IDLE;
      end
      if (pop) void'(mq.pop_front());
      if (bus.h2f_write) begin
        if (occ < DEPTH || pop) mq.push_back(bus.h2f_io);
        else                    m_ovf = 1'b1;
      end
    end
    m_status = snap;
  endtask

  task automatic check_outputs();
    check_eq("inst_valid", 32'(bus.inst_valid), 32'(m_valid));
    check_eq("inst", bus.inst, m_inst);
    check_eq("queue_empty", 32'(bus.queue_empty), 32'(mq.size() == 0));
    check_eq("queue_full", 32'(bus.queue_full), 32'(mq.size() == DEPTH));
    check_eq("f2h_status", bus.f2h_status, m_status);
  endtask

  // Drive one cycle of inputs, step the model, clock, then compare
  task automatic cyc(input logic w, input logic [31:0] d, input logic f,
                     input logic r, input logic dn);
    bus.h2f_write  = w;
    bus.h2f_io     = d;
    bus.h2f_flush  = f;
    bus.inst_ready = r;
    bus.inst_done  = dn;
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  // Wait (bounded) for an issue, check the word, accept it and signal done
  task automatic issue_one(input string tag, input logic [31:0] exp);
    int n = 0;
    while (!bus.inst_valid && n < 20) begin
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    check_eq({tag, "_valid"}, 32'(bus.inst_valid), 32'd1);
    check_eq({tag, "_word"}, bus.inst, exp);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    bus.h2f_write  = 1'b0;
    bus.h2f_io     = '0;
    bus.h2f_flush  = 1'b0;
    bus.inst_ready = 1'b0;
    bus.inst_done  = 1'b0;

    // T1 reset
    do_reset();
    check_eq("t1_status", bus.f2h_status, 32'h0000_0100);
    check_eq("t1_valid", 32'(bus.inst_valid), 32'd0);
    check_eq("t1_empty", 32'(bus.queue_empty), 32'd1);

    // T2 single issue with fixed latency
    cyc(1'b1, 32'h1234_5678, 1'b0, 1'b1, 1'b0);
    check_eq("t2_valid_e0", 32'(bus.inst_valid), 32'd0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check_eq("t2_valid_e1", 32'(bus.inst_valid), 32'd1);
    check_eq("t2_inst", bus.inst, 32'h1234_5678);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check_eq("t2_valid_e2", 32'(bus.inst_valid), 32'd0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check_eq("t2_status_wait", bus.f2h_status, 32'h0001_1100);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check_eq("t2_status_idle", bus.f2h_status, 32'h0001_0100);

    // T3 backpressure
    do_reset();
    cyc(1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check_eq("t3_valid", 32'(bus.inst_valid), 32'd1);
    check_eq("t3_inst", bus.inst, 32'hA5A5_0001);
    check_eq("t3_count", 32'(bus.f2h_status[7:0]), 32'd1);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check_eq("t3_popped", 32'(bus.queue_empty), 32'd1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // T4 full / overflow
    do_reset();
    for (int i = 1; i <= 17; i++) cyc(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check_eq("t4_full", 32'(bus.queue_full), 32'd1);
    check_eq("t4_count", 32'(bus.f2h_status[7:0]), 32'd16);
    check_eq("t4_overflow", 32'(bus.f2h_status[10]), 32'd1);
    for (int i = 1; i <= 16; i++) issue_one("t4_order", 32'(i));
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check_eq("t4_no_17th", 32'(bus.inst_valid), 32'd0);

    // T5 ordering
    do_reset();
    for (int i = 1; i <= 3; i++) cyc(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) issue_one("t5_order", 32'(i));
    check_eq("t5_issue_cnt", 32'(bus.f2h_status[31:16]), 32'd3);
    check_eq("t5_empty", 32'(bus.queue_empty), 32'd1);

    // T6 flush in S_ISSUE with a same-cycle write
    do_reset();
    for (int i = 1; i <= 3; i++) cyc(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 1'b0);
    check_eq("t6_pre_valid", 32'(bus.inst_valid), 32'd1);
    cyc(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
    check_eq("t6_valid", 32'(bus.inst_valid), 32'd0);
    check_eq("t6_empty", 32'(bus.queue_empty), 32'd1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check_eq("t6_status", 32'(bus.f2h_status[10:0]), 32'h100);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check_eq("t6_no_issue", 32'(bus.inst_valid), 32'd0);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 999) == 0);
      cyc(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 149) == 0),
          1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
